demux2way32_reg: RTL and testbench
==================================

DEMUX2WAY32_REG -- requirements
Module: demux2way32_reg

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the per-port delivered-word counters.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream word present.
REQ-005 SHALL have port in_ready  output  1  block accepts word this cycle.
REQ-006 SHALL have port in_address  input  1  destination select; 0 = port 0, 1 = port 1.
REQ-007 SHALL have port in_data  input  32  upstream word.
REQ-008 SHALL have port out0_valid  output  1  port 0 holding register full.
REQ-009 SHALL have port out0_ready  input  1  port 0 consumer accepts.
REQ-010 SHALL have port out0_data  output  32  port 0 holding register contents.
REQ-011 SHALL have port out1_valid  output  1  port 1 holding register full.
REQ-012 SHALL have port out1_ready  input  1  port 1 consumer accepts.
REQ-013 SHALL have port out1_data  output  32  port 1 holding register contents.
REQ-014 SHALL have port count0  output  CNT_W  words delivered on port 0.
REQ-015 SHALL have port count1  output  CNT_W  words delivered on port 1.

Function
REQ-016 SHALL hold one 32-bit holding register plus valid flag per output port, i.e. one word of buffering per port; out<n>_valid and out<n>_data SHALL be driven directly from these registers.
REQ-017 SHALL define input accept as in_valid & in_ready, and port-n drain as out<n>_valid & out<n>_ready, both evaluated in the same cycle.
REQ-018 SHALL drive in_ready combinationally = ~reset & (~out<a>_valid | out<a>_ready), where a = in_address.
REQ-019 in_ready SHALL depend only on the port selected by in_address; a full non-selected port SHALL NOT stall input.
REQ-020 On accept, SHALL load in_data into holding register a and set out<a>_valid at the next edge: one-cycle latency from accept to out<a>_valid = 1.
REQ-021 On drain of port n with no simultaneous accept to port n, SHALL clear out<n>_valid at the next edge; out<n>_data SHALL retain its last value.
REQ-022 Simultaneous drain and accept on the same port SHALL load the new word and keep out<n>_valid = 1 (full-throughput pass-through, one word per cycle).
REQ-023 While out<n>_valid = 1 and out<n>_ready = 0, out<n>_data SHALL remain stable.
REQ-024 Accept to one port and drain of the other in the same cycle SHALL both take effect independently.
REQ-025 in_data and in_address SHALL be sampled only on accept; their values in other cycles SHALL have no effect.
REQ-026 Per-port word order SHALL be preserved; relative order between ports is not guaranteed.
REQ-027 count<n> SHALL increment by 1 on each port-n drain, wrapping from 2^CNT_W-1 to 0 with no flag.
REQ-028 The block SHALL never drop or duplicate a word: every accept produces exactly one drain on its selected port.

Reset
REQ-029 While reset = 1 at a rising edge, SHALL set out0_valid = out1_valid = 0, out0_data = out1_data = 0, count0 = count1 = 0.
REQ-030 in_ready SHALL be 0 in any cycle with reset = 1; no accept SHALL occur.
REQ-031 Reset asserted mid-operation SHALL discard buffered words; no drain SHALL occur in the reset cycle, counters SHALL NOT increment.
REQ-032 First accept SHALL be possible in the first cycle with reset = 0 (in_ready = 1, both ports empty).

Verification
REQ-033 Basic route: after reset, in_valid=1, in_address=1, in_data=32'hDEADBEEF, out1_ready=0 -> next cycle out1_valid=1, out1_data=32'hDEADBEEF, out0_valid=0, count1=0.
REQ-034 Backpressure: port 0 full with 32'h1, out0_ready=0, in_address=0, in_valid=1 -> in_ready=0, out0_data stays 32'h1 over 5 cycles; switching in_address=1 -> in_ready=1 and word lands on port 1.
REQ-035 Streaming: out0_ready=1 held, 8 back-to-back words 0..7 to port 0 -> in_ready=1 every cycle, out0_data = 0..7 on consecutive cycles, count0=8.
REQ-036 Simultaneous: port 0 full, accept to port 1 while out0_ready=1 -> same edge clears out0_valid, sets out1_valid, count0 increments by 1.
REQ-037 Counter wrap: CNT_W=4, 17 drains on port 1 -> count1=1, count0=0.
REQ-038 Reset mid-operation: both ports full, count0=3, assert reset one cycle -> all valids 0, data 0, counts 0, in_ready=0 during reset, 1 the cycle after.

Source files
------------

// File: rtl/demux2way32_reg.sv
// rtl/demux2way32_reg.sv - 1-to-2 registered demultiplexer for 32-bit words with per-port delivery counters
//
// Purpose:
//   Routes each accepted upstream word to one of two output ports. Each port
//   has a single holding register and a valid flag. A port can accept a new
//   word in the same cycle that it hands its current word to the consumer,
//   so one port can pass one word per cycle.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   in_valid     upstream word present
//   in_ready     block accepts the word this cycle (combinational)
//   in_address   destination select: 0 = port 0, 1 = port 1
//   in_data      upstream word (32 bits)
//   out0_valid   port 0 holding register full
//   out0_ready   port 0 consumer accepts
//   out0_data    port 0 holding register contents
//   out1_valid   port 1 holding register full
//   out1_ready   port 1 consumer accepts
//   out1_data    port 1 holding register contents
//   count0       words delivered on port 0 (wraps)
//   count1       words delivered on port 1 (wraps)

module demux2way32_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_address,
  input  logic [31:0]      in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [31:0]      out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [31:0]      out1_data,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1
);

  logic             r_valid0;
  logic             r_valid1;
  logic [31:0]      r_data0;
  logic [31:0]      r_data1;
  logic [CNT_W-1:0] r_count0;
  logic [CNT_W-1:0] r_count1;

  logic w_space0;
  logic w_space1;
  logic w_accept;
  logic w_accept0;
  logic w_accept1;
  logic w_drain0;
  logic w_drain1;

  // A port has room if it is empty or its word leaves this cycle. Only the
  // addressed port matters, so a stalled neighbour never blocks traffic.
  assign w_space0  = ~r_valid0 | out0_ready;
  assign w_space1  = ~r_valid1 | out1_ready;
  assign in_ready  = ~reset & (in_address ? w_space1 : w_space0);

  assign w_accept  = in_valid & in_ready;
  assign w_accept0 = w_accept & ~in_address;
  assign w_accept1 = w_accept &  in_address;
  assign w_drain0  = r_valid0 & out0_ready;
  assign w_drain1  = r_valid1 & out1_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      r_data0  <= 32'h0;
      r_data1  <= 32'h0;
      r_count0 <= '0;
      r_count1 <= '0;
    end else begin
      // A new word takes priority over a drain: drain + accept keeps valid high.
      if (w_accept0) begin
        r_data0  <= in_data;
        r_valid0 <= 1'b1;
      end else if (w_drain0) begin
        r_valid0 <= 1'b0;
      end

      if (w_accept1) begin
        r_data1  <= in_data;
        r_valid1 <= 1'b1;
      end else if (w_drain1) begin
        r_valid1 <= 1'b0;
      end

      if (w_drain0) r_count0 <= r_count0 + CNT_W'(1);
      if (w_drain1) r_count1 <= r_count1 + CNT_W'(1);
    end
  end

  assign out0_valid = r_valid0;
  assign out0_data  = r_data0;
  assign out1_valid = r_valid1;
  assign out1_data  = r_data1;
  assign count0     = r_count0;
  assign count1     = r_count1;

endmodule

// File: tb/tb_demux2way32_reg.sv
// tb/tb_demux2way32_reg.sv - scoreboard bench for demux2way32_reg

module tb_demux2way32_reg;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             in_address;
  logic [31:0]      in_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [31:0]      out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [31:0]      out1_data;
  logic [CNT_W-1:0] count0;
  logic [CNT_W-1:0] count1;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  demux2way32_reg #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_address (in_address),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .count0     (count0),
    .count1     (count1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge, then at the
  // falling edge check in_ready and record accepted words as expectations.
  task automatic step(input logic rst, input logic v, input logic a, input logic [31:0] d,
                      input logic r0, input logic r1, input logic exp_rdy);
    @(posedge clk);
    #1;
    reset      = rst;
    in_valid   = v;
    in_address = a;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    @(negedge clk);
    chk("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
    if (v && exp_rdy && !rst) begin
      if (a) q1.push_back(d);
      else   q0.push_back(d);
    end
  endtask

  // Monitor: every drain must match the oldest outstanding word of its port.
  always @(negedge clk) begin
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL port0 unexpected drain: got %h expected none", out0_data);
        end else begin
          chk("port0 data", out0_data, q0.pop_front());
        end
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL port1 unexpected drain: got %h expected none", out1_data);
        end else begin
          chk("port1 data", out1_data, q1.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_address = 1'b0; in_data = 32'h0;
    out0_ready = 1'b0; out1_ready = 1'b0;

    // Reset state, with a word offered and consumers ready
    step(1, 1, 0, 32'h55, 1, 1, 0);
    step(1, 1, 1, 32'h66, 1, 1, 0);
    chk("rst out0_valid", {31'h0, out0_valid}, 32'h0);
    chk("rst out1_valid", {31'h0, out1_valid}, 32'h0);
    chk("rst out0_data", out0_data, 32'h0);
    chk("rst out1_data", out1_data, 32'h0);
    chk("rst count0", 32'(count0), 32'h0);
    chk("rst count1", 32'(count1), 32'h0);

    // Basic route to port 1 in the first cycle out of reset
    step(0, 1, 1, 32'hDEADBEEF, 0, 0, 1);
    step(0, 0, 0, 32'h0, 0, 0, 1);
    chk("route out1_valid", {31'h0, out1_valid}, 32'h1);
    chk("route out1_data", out1_data, 32'hDEADBEEF);
    chk("route out0_valid", {31'h0, out0_valid}, 32'h0);
    chk("route count1", 32'(count1), 32'h0);
    step(0, 0, 0, 32'h0, 0, 1, 1);
    step(0, 0, 0, 32'h0, 0, 0, 1);
    chk("route drained", {31'h0, out1_valid}, 32'h0);
    chk("route count1 after", 32'(count1), 32'h1);

    // Backpressure on port 0 must not stall port 1
    step(0, 1, 0, 32'h1, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 32'h2, 0, 0, 0);
      chk("bp out0_data", out0_data, 32'h1);
      chk("bp out0_valid", {31'h0, out0_valid}, 32'h1);
    end
    step(0, 1, 1, 32'h3, 0, 0, 1);
    step(0, 0, 0, 32'h0, 0, 0, 0);
    chk("bp out1_valid", {31'h0, out1_valid}, 32'h1);
    chk("bp out1_data", out1_data, 32'h3);
    step(0, 0, 0, 32'h0, 1, 1, 1);
    step(0, 0, 0, 32'h0, 0, 0, 1);
    chk("bp count0", 32'(count0), 32'h1);
    chk("bp count1", 32'(count1), 32'h2);

    // Streaming 0..7 through port 0 at one word per cycle
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 32'(i), 1, 0, 1);
      if (i > 0) chk("stream out0_data", out0_data, 32'(i - 1));
    end
    step(0, 0, 0, 32'h0, 1, 0, 1);
    chk("stream last", out0_data, 32'h7);
    step(0, 0, 0, 32'h0, 0, 0, 1);
    chk("stream count0", 32'(count0), 32'h9);
    chk("stream empty", {31'h0, out0_valid}, 32'h0);

    // Accept to port 1 while port 0 drains in the same cycle
    step(0, 1, 0, 32'hA, 0, 0, 1);
    step(0, 1, 1, 32'hB, 1, 0, 1);
    step(0, 0, 0, 32'h0, 0, 0, 1);
    chk("simul out0_valid", {31'h0, out0_valid}, 32'h0);
    chk("simul out1_valid", {31'h0, out1_valid}, 32'h1);
    chk("simul out1_data", out1_data, 32'hB);
    chk("simul count0", 32'(count0), 32'hA);
    step(0, 0, 0, 32'h0, 0, 1, 1);

    // Reset mid-operation with both ports full and consumers ready
    step(0, 1, 0, 32'hC, 0, 0, 1);
    step(0, 1, 1, 32'hD, 0, 0, 1);
    step(1, 1, 0, 32'hE, 1, 1, 0);
    step(0, 0, 0, 32'h0, 0, 0, 1);
    chk("mid out0_valid", {31'h0, out0_valid}, 32'h0);
    chk("mid out1_valid", {31'h0, out1_valid}, 32'h0);
    chk("mid out0_data", out0_data, 32'h0);
    chk("mid out1_data", out1_data, 32'h0);
    chk("mid count0", 32'(count0), 32'h0);
    chk("mid count1", 32'(count1), 32'h0);

    // 17 drains on port 1 wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) step(0, 1, 1, 32'h100 + 32'(i), 0, 1, 1);
    step(0, 0, 0, 32'h0, 0, 1, 1);
    step(0, 0, 0, 32'h0, 0, 0, 1);
    chk("wrap count1", 32'(count1), 32'h1);
    chk("wrap count0", 32'(count0), 32'h0);

    chk("q0 empty", 32'(q0.size()), 32'h0);
    chk("q1 empty", 32'(q1.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
